multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 49 ++++
 rtl/multicycle_ctrl_if.sv | 33 +++
 rtl/multicycle_ctrl_outdec.sv | 71 +++++++
 rtl/multicycle_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state encoding, opcode
// constants, ALU/write-back select encodings and small decode helpers.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    function automatic logic op_is_legal(input logic [6:0] op);
        logic legal;
        case (op)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_RTYPE, OP_IALU: legal = 1'b1;
            default:                                                  legal = 1'b0;
        endcase
        return legal;
    endfunction

    // True in the state that completes an instruction of class op.
    function automatic logic is_final_state(input state_e st, input logic [6:0] op);
        logic fin;
        case (st)
            ST_WB:   fin = 1'b1;
            ST_EXEC: fin = (op == OP_BRANCH);
            ST_MEM:  fin = (op == OP_STORE);
            default: fin = 1'b0;
        endcase
        return fin;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-unit bus: instruction/status inputs from the datapath and the
// strobes/selects driven back to it.
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic [6:0]  opcode;
    logic        alu_zero;
    logic        mem_ready;
    logic        pc_we;
    logic        ir_we;
    logic        mem_re;
    logic        mem_we;
    logic        reg_we;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] retired;

    modport master (
        input  opcode, alu_zero, mem_ready,
        output pc_we, ir_we, mem_re, mem_we, reg_we,
               alu_src_b, alu_op, wb_sel, illegal, state, retired
    );

    modport slave (
        output opcode, alu_zero, mem_ready,
        input  pc_we, ir_we, mem_re, mem_we, reg_we,
               alu_src_b, alu_op, wb_sel, illegal, state, retired
    );

endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// ctrl_outdec: purely combinational map from (state, latched opcode, ALU zero
// flag) to the datapath control outputs.
module ctrl_outdec
    import multicycle_ctrl_pkg::*;
(
    input  state_e     i_state,
    input  logic [6:0] i_op_q,
    input  logic       i_alu_zero,
    output logic       o_pc_we,
    output logic       o_ir_we,
    output logic       o_mem_re,
    output logic       o_mem_we,
    output logic       o_reg_we,
    output logic       o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_wb_sel
);

    always_comb begin
        o_pc_we     = 1'b0;
        o_ir_we     = 1'b0;
        o_mem_re    = 1'b0;
        o_mem_we    = 1'b0;
        o_reg_we    = 1'b0;
        o_alu_src_b = 1'b0;
        o_alu_op    = ALU_ADD;
        o_wb_sel    = WB_ALU;

        case (i_state)
            ST_FETCH: begin
                o_mem_re = 1'b1;
                o_ir_we  = 1'b1;
                o_pc_we  = 1'b1;
            end
            ST_EXEC: begin
                case (i_op_q)
                    OP_LOAD, OP_STORE: begin
                        o_alu_src_b = 1'b1;
                        o_alu_op    = ALU_ADD;
                    end
                    OP_BRANCH: begin
                        o_alu_src_b = 1'b0;
                        o_alu_op    = ALU_SUB;
                        o_pc_we     = i_alu_zero;
                    end
                    OP_JAL:   o_pc_we = 1'b1;
                    OP_RTYPE: o_alu_op = ALU_FUNCT;
                    OP_IALU: begin
                        o_alu_op    = ALU_FUNCT;
                        o_alu_src_b = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                o_mem_re = (i_op_q == OP_LOAD);
                o_mem_we = (i_op_q == OP_STORE);
            end
            ST_WB: begin
                o_reg_we = 1'b1;
                case (i_op_q)
                    OP_LOAD: o_wb_sel = WB_MEM;
                    OP_JAL:  o_wb_sel = WB_PC4;
                    default: o_wb_sel = WB_ALU;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle instruction controller: state register, latched opcode and
// retired-instruction counter. Define MULTICYCLE_CTRL_MEMWAIT_EN to stall
// FETCH and MEM until mem_ready.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);

    state_e      r_state;
    state_e      w_next_state;
    logic [6:0]  r_op_q;
    logic [31:0] r_retired;

    logic        w_mem_done;
    logic        w_retire;
    logic        w_fetch_hold;
    logic        w_pc_we;
    logic        w_ir_we;
    logic        w_mem_we;
    logic        w_reg_we;

`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
    assign w_mem_done = bus.mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = bus.mem_ready;
    assign w_mem_done         = 1'b1;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH:  if (w_mem_done) w_next_state = ST_DECODE;
            ST_DECODE: w_next_state = op_is_legal(bus.opcode) ? ST_EXEC : ST_FETCH;
            ST_EXEC: begin
                case (r_op_q)
                    OP_LOAD, OP_STORE:         w_next_state = ST_MEM;
                    OP_JAL, OP_RTYPE, OP_IALU: w_next_state = ST_WB;
                    default:                   w_next_state = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (w_mem_done)
                    w_next_state = (r_op_q == OP_LOAD) ? ST_WB : ST_FETCH;
            end
            default:   w_next_state = ST_FETCH;
        endcase
    end

    // A stalled store in MEM has not completed yet, so it must not retire.
    assign w_retire = is_final_state(r_state, r_op_q) &&
                      ((r_state != ST_MEM) || w_mem_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_op_q    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_DECODE)
                r_op_q <= bus.opcode;
            if (w_retire)
                r_retired <= r_retired + 32'd1;
        end
    end

    ctrl_outdec u_outdec (
        .i_state     (r_state),
        .i_op_q      (r_op_q),
        .i_alu_zero  (bus.alu_zero),
        .o_pc_we     (w_pc_we),
        .o_ir_we     (w_ir_we),
        .o_mem_re    (bus.mem_re),
        .o_mem_we    (w_mem_we),
        .o_reg_we    (w_reg_we),
        .o_alu_src_b (bus.alu_src_b),
        .o_alu_op    (bus.alu_op),
        .o_wb_sel    (bus.wb_sel)
    );

    // PC/IR update only on the cycle the fetch actually completes; all write
    // strobes are forced off while reset is held.
    assign w_fetch_hold = (r_state == ST_FETCH) && !w_mem_done;

    assign bus.pc_we   = !rst && w_pc_we && !w_fetch_hold;
    assign bus.ir_we   = !rst && w_ir_we && !w_fetch_hold;
    assign bus.mem_we  = !rst && w_mem_we;
    assign bus.reg_we  = !rst && w_reg_we;
    assign bus.illegal = !rst && (r_state == ST_DECODE) && !op_is_legal(bus.opcode);

    assign bus.state   = r_state;
    assign bus.retired = r_retired;

endmodule
